// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared op/state encodings, flag positions and ALU helpers for alu_seq
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
    } alu_res_t;

    function automatic logic [3:0] make_flags(input logic [7:0] r, input logic c, input logic v);
        logic [3:0] f;
        f         = 4'h0;
        f[FLAG_Z] = (r == 8'h00);
        f[FLAG_C] = c;
        f[FLAG_N] = r[7];
        f[FLAG_V] = v;
        return f;
    endfunction

    // Single-cycle ops only; MUL is produced by the shift-add sub-module.
    function automatic alu_res_t alu_compute(input op_e op, input logic [7:0] a, input logic [7:0] b);
        alu_res_t   res;
        logic [8:0] wide;
        res  = '0;
        wide = 9'h000;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                res.r = wide[7:0];
                res.c = wide[8];
                res.v = (a[7] == b[7]) && (wide[7] != a[7]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                res.r = wide[7:0];
                res.c = wide[8];
                res.v = (a[7] != b[7]) && (wide[7] != a[7]);
            end
            OP_AND: res.r = a & b;
            OP_OR:  res.r = a | b;
            OP_XOR: res.r = a ^ b;
            OP_SHL: begin
                res.r = {a[6:0], 1'b0};
                res.c = a[7];
            end
            OP_SHR: begin
                res.r = {1'b0, a[7:1]};
                res.c = a[0];
            end
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/alu_mul8.sv
// rtl/alu_mul8.sv - 8x8 unsigned shift-add multiplier, one partial product per enabled cycle
module alu_mul8 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        en_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        last_o,
    output logic [15:0] prod_next_o
);

    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [15:0] prod_q, prod_d;
    logic [2:0]  cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = {8'h00, a_i};
            mplier_d = b_i;
            prod_d   = 16'h0000;
            cnt_d    = 3'd0;
        end else if (en_i) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : 16'h0000);
            mcand_d  = {mcand_q[14:0], 1'b0};
            mplier_d = {1'b0, mplier_q[7:1]};
            cnt_d    = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= 16'h0000;
            mplier_q <= 8'h00;
            prod_q   <= 16'h0000;
            cnt_q    <= 3'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    // The caller captures the final product on the same edge as iteration 7.
    assign last_o      = (cnt_q == 3'd7);
    assign prod_next_o = prod_d;

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential 8-bit ALU with IDLE/EXEC/MUL/DONE control and registered flags
module alu_seq
    import alu_seq_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Acc_in,
    input  logic [7:0] Bus_in,
    input  logic [2:0] Op,
    input  logic       Start,
    input  logic       OE,
    output logic [7:0] Result_out,
    output logic [3:0] Flags,
    output logic       Busy,
    output logic       Done
);

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    op_e        op_q, op_d;
    logic [7:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;

    logic        mul_start;
    logic        mul_en;
    logic        mul_last;
    logic [15:0] mul_prod;
    alu_res_t    exec_res;

    alu_mul8 u_mul (
        .clk_i       (CLK),
        .rst_i       (RESET),
        .start_i     (mul_start),
        .en_i        (mul_en),
        .a_i         (Acc_in),
        .b_i         (Bus_in),
        .last_o      (mul_last),
        .prod_next_o (mul_prod)
    );

    assign exec_res = alu_compute(op_q, a_q, b_q);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        result_d  = result_q;
        flags_d   = flags_q;
        mul_start = 1'b0;
        mul_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_d       = Acc_in;
                    b_d       = Bus_in;
                    op_d      = op_e'(Op);
                    mul_start = (op_e'(Op) == OP_MUL);
                    state_d   = (op_e'(Op) == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = exec_res.r;
                flags_d  = make_flags(exec_res.r, exec_res.c, exec_res.v);
                state_d  = S_DONE;
            end
            S_MUL: begin
                mul_en = 1'b1;
                if (mul_last) begin
                    result_d = mul_prod[7:0];
                    flags_d  = make_flags(mul_prod[7:0], |mul_prod[15:8], 1'b0);
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            a_q      <= 8'h00;
            b_q      <= 8'h00;
            op_q     <= OP_ADD;
            result_q <= 8'h00;
            flags_q  <= 4'h0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign Result_out = OE ? result_q : 8'h00;
    assign Flags      = flags_q;
    assign Busy       = (state_q == S_EXEC) || (state_q == S_MUL);
    assign Done       = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq
module tb_alu_seq;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] Acc_in;
    logic [7:0] Bus_in;
    logic [2:0] Op;
    logic       Start;
    logic       OE;
    logic [7:0] Result_out;
    logic [3:0] Flags;
    logic       Busy;
    logic       Done;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    alu_seq dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Acc_in     (Acc_in),
        .Bus_in     (Bus_in),
        .Op         (Op),
        .Start      (Start),
        .OE         (OE),
        .Result_out (Result_out),
        .Flags      (Flags),
        .Busy       (Busy),
        .Done       (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int ia, ib, sa, sb_, s, ss;
        logic c, v;
        ia = a; ib = b; sa = $signed(a); sb_ = $signed(b);
        c = 1'b0; v = 1'b0; s = 0;
        case (op)
            3'b000: begin s = ia + ib; c = (s > 255); ss = sa + sb_; v = (ss > 127) || (ss < -128); end
            3'b001: begin s = ia - ib; c = (ia < ib); ss = sa - sb_; v = (ss > 127) || (ss < -128); end
            3'b010: s = ia & ib;
            3'b011: s = ia | ib;
            3'b100: s = ia ^ ib;
            3'b101: begin s = ia * 2; c = a[7]; end
            3'b110: begin s = ia / 2; c = a[0]; end
            default: begin s = ia * ib; c = (s > 255); end
        endcase
        e.r = s[7:0];
        e.f = {(e.r == 8'h00), c, e.r[7], v};
        return e;
    endfunction

    // Drive one operation; disturb re-pulses Start and scrambles operands mid-operation.
    task automatic do_op(input string name, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic oe, input bit disturb);
        int   lat;
        int   busy_n;
        exp_t e;
        sb.push_back(model(op, a, b));
        @(negedge CLK);
        Op = op; Acc_in = a; Bus_in = b; Start = 1'b1; OE = oe;
        @(negedge CLK);
        Start = 1'b0;
        lat = 1; busy_n = 0;
        while (!Done && lat < 20) begin
            if (Busy) busy_n++;
            if (disturb && lat == 3) begin
                Start = 1'b1; Acc_in = ~a; Bus_in = 8'h55; Op = 3'b000;
            end else begin
                Start = 1'b0;
            end
            @(negedge CLK);
            lat++;
        end
        Start = 1'b0;
        check({name, ".latency"}, lat, (op == 3'b111) ? 9 : 2);
        check({name, ".busy_cycles"}, busy_n, (op == 3'b111) ? 8 : 1);
        e = sb.pop_front();
        check({name, ".result"}, Result_out, oe ? e.r : 8'h00);
        check({name, ".flags"}, Flags, e.f);
        @(negedge CLK);
        check({name, ".done_single"}, Done, 1'b0);
        check({name, ".busy_after"}, Busy, 1'b0);
        if (!oe) begin
            OE = 1'b1;
            #1;
            check({name, ".result_oe"}, Result_out, e.r);
            check({name, ".flags_oe"}, Flags, e.f);
        end
    endtask

    initial begin
        int done_seen;
        RESET = 1'b1; Acc_in = 8'h00; Bus_in = 8'h00; Op = 3'b000; Start = 1'b0; OE = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset.busy", Busy, 1'b0);
        check("reset.done", Done, 1'b0);
        check("reset.flags", Flags, 4'h0);
        check("reset.result", Result_out, 8'h00);
        RESET = 1'b0;

        do_op("add_ff_01", 3'b000, 8'hFF, 8'h01, 1'b1, 1'b0);
        check("add_ff_01.zc", Flags, 4'b1100);
        do_op("sub_80_01", 3'b001, 8'h80, 8'h01, 1'b1, 1'b0);
        check("sub_80_01.r", Result_out, 8'h7F);
        do_op("sub_03_05", 3'b001, 8'h03, 8'h05, 1'b1, 1'b0);
        check("sub_03_05.r", Result_out, 8'hFE);
        do_op("mul_10_20", 3'b111, 8'h10, 8'h20, 1'b1, 1'b0);
        do_op("mul_0c_0b", 3'b111, 8'h0C, 8'h0B, 1'b1, 1'b1);
        check("mul_0c_0b.r", Result_out, 8'h84);
        do_op("shl_81", 3'b101, 8'h81, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of a multiply: no Done, everything cleared.
        @(negedge CLK);
        Op = 3'b111; Acc_in = 8'hFF; Bus_in = 8'hFF; Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("mulrst.busy", Busy, 1'b0);
        check("mulrst.done", Done, 1'b0);
        check("mulrst.flags", Flags, 4'h0);
        check("mulrst.result", Result_out, 8'h00);
        done_seen = 0;
        repeat (10) begin
            @(negedge CLK);
            if (Done) done_seen++;
        end
        check("mulrst.no_done", done_seen, 0);

        do_op("shr_01_oe0", 3'b110, 8'h01, 8'h00, 1'b0, 1'b0);
        OE = 1'b0;
        #1;
        check("shr_01.oe_off", Result_out, 8'h00);
        check("shr_01.flags_hold", Flags, 4'b1100);
        OE = 1'b1;

        for (int i = 0; i < 24; i++) begin
            do_op("rand", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
